// File: rtl/hf_tag_modulator_pkg.sv
// Shared definitions for the HF tag-simulation transmitter: sequence codes,
// FSM states, byte record and default bit timing.
package hf_tag_modulator_pkg;

    localparam int BIT_PERIOD_DEF = 128;
    localparam int SUB_DIV_DEF    = 16;

    // FPGA major-mode code that routes this block onto the load-modulation path
    localparam logic [2:0] TAGSIM_MOD = 3'd3;

    typedef enum logic [1:0] { SEQ_D = 2'd0, SEQ_E = 2'd1, SEQ_F = 2'd2 } seq_e;
    typedef enum logic [2:0] { IDLE, START_WAIT, SOF, DATA, EOF } state_e;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } tx_byte_t;

    // Nine on-air bits, LSB first: data then odd parity
    function automatic logic [8:0] frame_byte(input logic [7:0] data);
        return {~^data, data};
    endfunction

endpackage

// File: rtl/hf_subcarrier_gen.sv
// Bit-period counter and Manchester subcarrier encoder; mod_load lags the
// sequence decode by one register stage.
module hf_subcarrier_gen
    import hf_tag_modulator_pkg::*;
#(
    parameter int BIT_PERIOD = BIT_PERIOD_DEF,
    parameter int SUB_DIV    = SUB_DIV_DEF
) (
    input  logic ck_1356meg,
    input  logic nrst,
    input  logic run,
    input  seq_e seq,
    output logic bit_wrap,
    output logic mod_load
);

    localparam int CW = $clog2(BIT_PERIOD);
    localparam int SW = $clog2(SUB_DIV);

    logic [CW-1:0] bit_cnt;
    logic          half;
    logic          sub_phase;
    logic          active;

    assign half      = bit_cnt[CW-1];
    assign sub_phase = bit_cnt[SW-1];
    assign bit_wrap  = run && (bit_cnt == CW'(BIT_PERIOD - 1));

    always_comb begin
        active = 1'b0;
        case (seq)
            SEQ_D:   active = ~half;
            SEQ_E:   active = half;
            default: active = 1'b0;
        endcase
    end

    always_ff @(negedge ck_1356meg or negedge nrst) begin
        if (!nrst) begin
            bit_cnt  <= '0;
            mod_load <= 1'b0;
        end else begin
            bit_cnt  <= run ? bit_cnt + 1'b1 : '0;
            mod_load <= run & active & ~sub_phase;
        end
    end

endmodule

// File: rtl/hf_tag_modulator.sv
// ISO14443-A tag response transmitter: holding register, framing FSM and
// fc/16 subcarrier load modulation.
module hf_tag_modulator
    import hf_tag_modulator_pkg::*;
#(
    parameter int BIT_PERIOD  = BIT_PERIOD_DEF,
    parameter int SUB_DIV     = SUB_DIV_DEF,
    parameter int START_DELAY = 0
) (
    input  logic       ck_1356meg,
    input  logic       nrst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       mod_load,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun
);

    localparam logic [9:0] WAIT_LAST = 10'((START_DELAY > 0) ? START_DELAY - 1 : 0);

    state_e     state;
    tx_byte_t   hold;
    logic       hold_valid;
    logic [8:0] shreg;
    logic       cur_last;
    logic [3:0] bit_idx;
    logic [9:0] wait_cnt;
    logic       accept;
    logic       run;
    logic       bit_wrap;
    seq_e       seq;

    assign tx_ready = ~hold_valid;
    assign accept   = tx_valid & ~hold_valid;
    assign run      = (state == SOF) || (state == DATA) || (state == EOF);

    always_comb begin
        seq = SEQ_F;
        case (state)
            SOF:     seq = SEQ_D;
            DATA:    seq = shreg[0] ? SEQ_D : SEQ_E;
            default: seq = SEQ_F;
        endcase
    end

    hf_subcarrier_gen #(
        .BIT_PERIOD (BIT_PERIOD),
        .SUB_DIV    (SUB_DIV)
    ) u_subcarrier (
        .ck_1356meg (ck_1356meg),
        .nrst       (nrst),
        .run        (run),
        .seq        (seq),
        .bit_wrap   (bit_wrap),
        .mod_load   (mod_load)
    );

    always_ff @(negedge ck_1356meg or negedge nrst) begin
        if (!nrst) begin
            state      <= IDLE;
            hold       <= '0;
            hold_valid <= 1'b0;
            shreg      <= '0;
            cur_last   <= 1'b0;
            bit_idx    <= '0;
            wait_cnt   <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            underrun   <= 1'b0;
            if (accept) begin
                hold       <= '{data: tx_data, last: tx_last};
                hold_valid <= 1'b1;
            end
            case (state)
                IDLE: begin
                    // A byte parked after the previous frame's last byte starts the next frame
                    if (hold_valid || accept) begin
                        busy     <= 1'b1;
                        wait_cnt <= '0;
                        if (START_DELAY == 0) state <= SOF;
                        else                  state <= START_WAIT;
                    end else if (frame_done) begin
                        busy <= 1'b0;
                    end
                end
                START_WAIT: begin
                    if (wait_cnt == WAIT_LAST) state <= SOF;
                    else                       wait_cnt <= wait_cnt + 1'b1;
                end
                SOF: begin
                    if (bit_wrap) begin
                        shreg      <= frame_byte(hold.data);
                        cur_last   <= hold.last;
                        hold_valid <= 1'b0;
                        bit_idx    <= '0;
                        state      <= DATA;
                    end
                end
                DATA: begin
                    if (bit_wrap) begin
                        if (bit_idx != 4'd8) begin
                            shreg   <= {1'b0, shreg[8:1]};
                            bit_idx <= bit_idx + 1'b1;
                        end else if (cur_last) begin
                            state <= EOF;
                        end else if (hold_valid) begin
                            shreg      <= frame_byte(hold.data);
                            cur_last   <= hold.last;
                            hold_valid <= 1'b0;
                            bit_idx    <= '0;
                        end else begin
                            // Nothing to send next: truncate the frame rather than stall mid-air
                            underrun <= 1'b1;
                            state    <= EOF;
                        end
                    end
                end
                EOF: begin
                    if (bit_wrap) begin
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
